clint_timer: RTL and testbench
==============================

Name: clint_timer

Overview:
- Core-local interruptor feeding the CSR unit.
- Holds the machine timer (mtime), its compare register (mtimecmp) and, optionally, the software-interrupt bit (msip).
- Drives clint_mtip, which the CSR unit samples to set mip.MTIP and raise a timer trap.
- Exposes a single-outstanding valid/ready memory-mapped slave port, driven by the LSU/AXI bridge for loads and stores in the CLINT address window.

Parameters:
- BASE_ADDR, 64'h0200_0000: CLINT window base.
- TICK_DIV, 1: mtime increments once every TICK_DIV clk cycles. Legal range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  slave can accept a request
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  64  byte address, 8-byte aligned
- req_wdata  in  64  write data
- req_wstrb  in  8  byte enables for writes
- resp_valid  out  1  response present
- resp_ready  in  1  master accepts response
- resp_rdata  out  64  read data; 0 for writes and errors
- resp_err  out  1  unmapped or misaligned access
- clint_mtip  out  1  timer interrupt pending
- clint_msip  out  1  software interrupt pending (see Optional Feature)

Behaviour:
- Reset (async, active-high): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, FSM=IDLE.
  - Output values under reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, clint_mtip=0, clint_msip=0.
- Address map (offset from BASE_ADDR):
  - 0x0000 msip: bit 0 only.
  - 0x4000 mtimecmp.
  - 0xBFF8 mtime.
  - Any other offset, or addr[2:0]!=0: error.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps.
  - A tick is asserted in the cycle where prescaler==TICK_DIV-1; mtime increments by 1 at that edge.
  - mtime wraps from all-ones to 0 with no flag.
- FSM has two states, IDLE and RESP.
  - IDLE: req_ready=1. On req_valid, the request is accepted at that edge and the FSM goes to RESP.
  - RESP: req_ready=0, resp_valid=1, and resp_rdata/resp_err are held stable. When resp_ready=1 the FSM returns to IDLE. There is no back-to-back acceptance in the cycle the response completes.
  - Turnaround is 1-cycle minimum request-to-response latency; throughput is one access per 2 cycles.
- Writes:
  - Applied at the acceptance edge, per byte: byte i is updated iff req_wstrb[i].
  - A write to mtime in the same edge as a tick: the written bytes take the write value and unwritten bytes keep the old value, with no increment that edge. The prescaler keeps running.
  - A write with error does not modify any register.
- Reads:
  - resp_rdata is captured at the acceptance edge from the pre-edge register value (mtime before that edge's increment).
  - msip reads as {63'b0, msip}.
- clint_mtip = (mtime >= mtimecmp), unsigned 64-bit comparison, combinational from registers.
  - Level signal; it clears only when mtimecmp is raised above mtime or mtime wraps.
  - Visible to the CSR unit in the cycle after a write lands.
- Reset asserted mid-transaction: FSM goes to IDLE immediately, the response is dropped and all registers take reset values. The master must reissue.

Optional Feature:
- Macro: CLINT_MSIP_EN.
- Defined: the msip register exists, the 0x0000 offset is decoded, and clint_msip = msip.
- Undefined: there is no msip flop. Offset 0x0000 reads 0 with resp_err=0, writes are ignored without error, and clint_msip is tied 0.

Test Plan:
- Reset then idle, TICK_DIV=1: after 10 cycles, a read of 0x0200_BFF8 returns the mtime value at the acceptance cycle (monotonic, ≥10 after the release edge); clint_mtip=0.
- Compare hit: write mtimecmp=0x40 (wstrb=8'hFF) → clint_mtip rises in the first cycle mtime==0x40. Then write mtimecmp=0x1000 → clint_mtip=0 the next cycle.
- Partial write and collision: mtime=0x1122_3344_5566_7788, write 0xAA with wstrb=8'h01 on a tick edge → mtime=0x1122_3344_5566_77AA with no increment that edge.
- Prescaler, TICK_DIV=4: 40 cycles after reset release mtime=10; wrap test presets mtime=64'hFFFF_FFFF_FFFF_FFFF → 0 after 4 cycles.
- Handshake and errors: hold resp_ready=0 for 5 cycles → resp_valid held, rdata stable, req_ready=0. A read of 0x0200_0008 → resp_err=1 and rdata=0; misaligned 0x0200_4004 → resp_err=1 with mtimecmp unchanged.
- Mid-transaction reset: pulse rst while in RESP → resp_valid=0, req_ready=1, mtimecmp=all-ones. With CLINT_MSIP_EN, writing 1 to 0x0200_0000 → clint_msip=1 and a read returns 1; without the macro the read returns 0 and clint_msip=0.

Source files
------------

// File: rtl/clint_timer_if.sv
// Single-outstanding valid/ready bus into the CLINT register window.
// The LSU/AXI bridge is the master; clint_timer is the slave.
interface clint_timer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr,
    output req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/clint_timer.sv
// Core-local timer: mtime, mtimecmp and clint_mtip for the CSR unit.
// Define CLINT_MSIP_EN to add the msip software-interrupt register.
module clint_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic         clk,
  input  logic         rst,
  clint_timer_if.slave bus,
  output logic         clint_mtip,
  output logic         clint_msip
);

  localparam logic [63:0] OFF_MSIP = 64'h0000;
  localparam logic [63:0] OFF_CMP  = 64'h4000;
  localparam logic [63:0] OFF_TIME = 64'hBFF8;
  localparam logic [15:0] PRE_MAX  =
    16'(TICK_DIV - 1);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t      state;
  logic        ready_q;
  logic        valid_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [15:0] presc;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip_q;

  logic [63:0] off;
  logic        aligned;
  logic        hit_msip;
  logic        hit_cmp;
  logic        hit_time;
  logic        dec_err;
  logic        accept;
  logic        wr_en;
  logic [63:0] wmask;
  logic [63:0] rd_mux;

  assign tick = (presc == PRE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  assign off      = bus.req_addr - BASE_ADDR;
  assign aligned  = (bus.req_addr[2:0] == 3'b000);
  assign hit_msip = aligned && (off == OFF_MSIP);
  assign hit_cmp  = aligned && (off == OFF_CMP);
  assign hit_time = aligned && (off == OFF_TIME);
  assign dec_err  = !(hit_msip || hit_cmp || hit_time);

  assign accept = bus.req_valid && (state == IDLE);
  assign wr_en  = accept && bus.req_wen && !dec_err;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 8; i++) begin
      wmask[8*i +: 8] = {8{bus.req_wstrb[i]}};
    end
  end

  // A write wins over the tick; the prescaler is not disturbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr_en && hit_time) begin
      mtime <= (mtime & ~wmask)
             | (bus.req_wdata & wmask);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= '1;
    end else if (wr_en && hit_cmp) begin
      mtimecmp <= (mtimecmp & ~wmask)
                | (bus.req_wdata & wmask);
    end
  end

`ifdef CLINT_MSIP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip_q <= 1'b0;
    end else if (wr_en && hit_msip
                 && bus.req_wstrb[0]) begin
      msip_q <= bus.req_wdata[0];
    end
  end
`else
  assign msip_q = 1'b0;
`endif

  assign clint_msip = msip_q;
  assign clint_mtip = (mtime >= mtimecmp);

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_msip: rd_mux = {63'b0, msip_q};
      hit_cmp:  rd_mux = mtimecmp;
      hit_time: rd_mux = mtime;
      default:  rd_mux = '0;
    endcase
  end

  // Response is captured at acceptance from pre-edge register values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state   <= RESP;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
            err_q   <= dec_err;
            rdata_q <= (bus.req_wen || dec_err)
                     ? 64'd0 : rd_mux;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one instance at TICK_DIV=1,
// one at TICK_DIV=4, each with its own reset.
module tb_clint_timer;

  localparam logic [63:0] A_MSIP = 64'h0200_0000;
  localparam logic [63:0] A_CMP  = 64'h0200_4000;
  localparam logic [63:0] A_TIME = 64'h0200_BFF8;
  localparam logic [63:0] ONES   = '1;
`ifdef CLINT_MSIP_EN
  localparam logic [63:0] MSIP_EXP = 64'd1;
`else
  localparam logic [63:0] MSIP_EXP = 64'd0;
`endif

  logic clk = 1'b0;
  logic rst1;
  logic rst4;
  logic mtip1, msip1, mtip4, msip4;

  logic        wen_d;
  logic [63:0] addr_d;
  logic [63:0] wdata_d;
  logic [7:0]  wstrb_d;
  logic        rv1, rv4, rr1, rr4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clint_timer_if b1 ();
  clint_timer_if b4 ();

  assign b1.req_valid  = rv1;
  assign b1.req_wen    = wen_d;
  assign b1.req_addr   = addr_d;
  assign b1.req_wdata  = wdata_d;
  assign b1.req_wstrb  = wstrb_d;
  assign b1.resp_ready = rr1;
  assign b4.req_valid  = rv4;
  assign b4.req_wen    = wen_d;
  assign b4.req_addr   = addr_d;
  assign b4.req_wdata  = wdata_d;
  assign b4.req_wstrb  = wstrb_d;
  assign b4.resp_ready = rr4;

  clint_timer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1.slave),
    .clint_mtip(mtip1), .clint_msip(msip1)
  );

  clint_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .bus(b4.slave),
    .clint_mtip(mtip4), .clint_msip(msip4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Starts just after a posedge; accept at the next edge, complete
  // at the one after, and return just after that edge.
  task automatic xact(input bit s4, input logic wen,
                      input logic [63:0] addr,
                      input logic [63:0] wdata,
                      input logic [7:0] wstrb,
                      output logic [63:0] rd,
                      output logic er, output logic mt);
    wen_d = wen; addr_d = addr;
    wdata_d = wdata; wstrb_d = wstrb;
    if (s4) rv4 = 1'b1; else rv1 = 1'b1;
    @(posedge clk); #1;
    chk("xact_valid",
        s4 ? b4.resp_valid : b1.resp_valid, 1);
    rd = s4 ? b4.resp_rdata : b1.resp_rdata;
    er = s4 ? b4.resp_err : b1.resp_err;
    mt = s4 ? mtip4 : mtip1;
    rv1 = 1'b0; rv4 = 1'b0;
    if (s4) rr4 = 1'b1; else rr1 = 1'b1;
    @(posedge clk); #1;
    rr1 = 1'b0; rr4 = 1'b0;
  endtask

  logic [63:0] rd;
  logic        er, mt;

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    rv1 = 0; rv4 = 0; rr1 = 0; rr4 = 0;
    wen_d = 0; addr_d = '0; wdata_d = '0; wstrb_d = '0;

    repeat (2) @(posedge clk); #1;
    chk("rst_req_ready", b1.req_ready, 1);
    chk("rst_resp_valid", b1.resp_valid, 0);
    chk("rst_rdata", b1.resp_rdata, 0);
    chk("rst_err", b1.resp_err, 0);
    chk("rst_mtip", mtip1, 0);
    chk("rst_msip", msip1, 0);

    @(negedge clk);
    rst1 = 1'b0; rst4 = 1'b0;
    repeat (10) @(posedge clk); #1;

    // edge 11 accepts; mtime was 10 before it
    xact(0, 0, A_TIME, 0, 8'h00, rd, er, mt);
    chk("idle_mtime", rd, 64'd10);
    chk("idle_mtip", mtip1, 0);

    // TICK_DIV=4: accept at edge 41 sees mtime 10
    repeat (28) @(posedge clk); #1;
    xact(1, 0, A_TIME, 0, 8'h00, rd, er, mt);
    chk("div4_mtime", rd, 64'd10);

    // preset all-ones on tick edge 44, wraps on edge 48
    @(posedge clk); #1;
    xact(1, 1, A_TIME, ONES, 8'hFF, rd, er, mt);
    xact(1, 0, A_TIME, 0, 8'h00, rd, er, mt);
    chk("wrap_pre", rd, ONES);
    chk("wrap_mtip_set", mt, 1);
    xact(1, 0, A_TIME, 0, 8'h00, rd, er, mt);
    chk("wrap_mtip_clr", mtip4, 0);
    xact(1, 0, A_TIME, 0, 8'h00, rd, er, mt);
    chk("wrap_zero", rd, 64'd0);

    // tick edges 52 and 56: full write then byte-0 write
    xact(1, 1, A_TIME, 64'h1122_3344_5566_7788,
         8'hFF, rd, er, mt);
    repeat (2) @(posedge clk); #1;
    xact(1, 1, A_TIME, 64'hAA, 8'h01, rd, er, mt);
    xact(1, 0, A_TIME, 0, 8'h00, rd, er, mt);
    chk("partial_tick", rd, 64'h1122_3344_5566_77AA);

    // compare hit on the TICK_DIV=1 instance
    xact(0, 1, A_TIME, 64'h30, 8'hFF, rd, er, mt);
    chk("wr_time_err", er, 0);
    xact(0, 1, A_CMP, 64'h40, 8'hFF, rd, er, mt);
    chk("cmp_early", mtip1, 0);
    repeat (12) @(posedge clk); #1;
    chk("cmp_3f", mtip1, 0);
    @(posedge clk); #1;
    chk("cmp_hit", mtip1, 1);
    xact(0, 1, A_CMP, 64'h1000, 8'hFF, rd, er, mt);
    chk("cmp_raise", mt, 0);

    // stalled response: mtime is 0x42 before the accept edge
    wen_d = 0; addr_d = A_TIME; rv1 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0;
    chk("stall_rdata0", b1.resp_rdata, 64'h42);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", b1.resp_valid, 1);
      chk("stall_rdata", b1.resp_rdata, 64'h42);
      chk("stall_ready", b1.req_ready, 0);
    end
    rr1 = 1'b1;
    @(posedge clk); #1;
    rr1 = 1'b0;
    chk("stall_done_valid", b1.resp_valid, 0);
    chk("stall_done_ready", b1.req_ready, 1);

    xact(0, 0, 64'h0200_0008, 0, 8'h00, rd, er, mt);
    chk("unmapped_err", er, 1);
    chk("unmapped_rdata", rd, 0);
    xact(0, 1, 64'h0200_4004, 0, 8'hFF, rd, er, mt);
    chk("misalign_err", er, 1);
    xact(0, 0, A_CMP, 0, 8'h00, rd, er, mt);
    chk("misalign_keep", rd, 64'h1000);
    chk("cmp_rd_err", er, 0);

    xact(0, 1, A_MSIP, 64'd1, 8'h01, rd, er, mt);
    chk("msip_wr_err", er, 0);
    chk("msip_pin", msip1, MSIP_EXP);
    xact(0, 0, A_MSIP, 0, 8'h00, rd, er, mt);
    chk("msip_rd", rd, MSIP_EXP);
    chk("msip_rd_err", er, 0);

    // reset while a response is outstanding
    xact(0, 1, A_CMP, 64'h55, 8'hFF, rd, er, mt);
    wen_d = 0; addr_d = A_CMP; rv1 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0;
    chk("mid_in_resp", b1.resp_valid, 1);
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    chk("mid_valid", b1.resp_valid, 0);
    chk("mid_ready", b1.req_ready, 1);
    chk("mid_mtip", mtip1, 0);
    chk("mid_msip", msip1, 0);
    @(negedge clk);
    rst1 = 1'b0;
    @(posedge clk); #1;
    xact(0, 0, A_CMP, 0, 8'h00, rd, er, mt);
    chk("mid_cmp", rd, ONES);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
